// File: rtl/thresh_bbox_pkg.sv
// Shared types and constants for the threshold / bounding-box block.
package thresh_bbox_pkg;

  localparam int COORD_W = 16;

  // An empty box is reported as min=all-ones, max=0 so any real pixel replaces it.
  localparam logic [COORD_W-1:0] COORD_MIN_RESET = 16'hFFFF;
  localparam logic [COORD_W-1:0] COORD_MAX_RESET = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/thresh_bbox_accum.sv
// Min/max coordinate and saturating foreground-count accumulators for one frame.
module bbox_accum
  import thresh_bbox_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_init,
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic [COORD_W-1:0] o_minX,
  output logic [COORD_W-1:0] o_maxX,
  output logic [COORD_W-1:0] o_minY,
  output logic [COORD_W-1:0] o_maxY,
  output logic [CNT_W-1:0]   o_count
);

  logic [COORD_W-1:0] r_minX, r_maxX, r_minY, r_maxY;
  logic [CNT_W-1:0]   r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_init) begin
      r_minX  <= COORD_MIN_RESET;
      r_maxX  <= COORD_MAX_RESET;
      r_minY  <= COORD_MIN_RESET;
      r_maxY  <= COORD_MAX_RESET;
      r_count <= '0;
    end else if (i_en) begin
      if (i_x < r_minX) r_minX <= i_x;
      if (i_x > r_maxX) r_maxX <= i_x;
      if (i_y < r_minY) r_minY <= i_y;
      if (i_y > r_maxY) r_maxY <= i_y;
      // Count sticks at all-ones rather than wrapping.
      if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
    end
  end

  assign o_minX  = r_minX;
  assign o_maxX  = r_maxX;
  assign o_minY  = r_minY;
  assign o_maxY  = r_maxY;
  assign o_count = r_count;

endmodule

// File: rtl/thresh_bbox.sv
// Binarises greyscale pixels against a per-frame threshold and reports the foreground bounding box.
// Optional feature macro: THRESH_BBOX_OVERLAY_EN adds the oOverlay box-border output.
module thresh_bbox
  import thresh_bbox_pkg::*;
#(
  parameter int MIN_COUNT = 64,
  parameter int CNT_W     = 20
) (
  input  logic               iPclk,
  input  logic               iRst,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic               Dval,
  input  logic               Fval,
  input  logic [11:0]        Grey,
  input  logic [7:0]         iThresh,
  output logic               oBin,
  output logic               oBinDval,
  output logic [COORD_W-1:0] oMinX,
  output logic [COORD_W-1:0] oMaxX,
  output logic [COORD_W-1:0] oMinY,
  output logic [COORD_W-1:0] oMaxY,
  output logic [CNT_W-1:0]   oCount,
  output logic               oBoxValid,
`ifdef THRESH_BBOX_OVERLAY_EN
  output logic               oOverlay,
`endif
  output logic [1:0]         oState
);

  state_t             r_state, w_nextState;
  logic               r_fvalPrev;
  logic [7:0]         r_thrQ;
  logic               r_fg1, r_dv1;
  logic [COORD_W-1:0] r_x1, r_y1;
  logic               w_fvalRise, w_fvalFall, w_fg, w_init, w_report, w_accEn;
  logic [7:0]         w_thrEff;
  logic [COORD_W-1:0] w_accMinX, w_accMaxX, w_accMinY, w_accMaxY;
  logic [CNT_W-1:0]   w_accCount;
  logic               w_unusedGreyLsb;

  assign w_unusedGreyLsb = ^Grey[3:0];
  assign w_fvalRise = Fval & ~r_fvalPrev;
  assign w_fvalFall = ~Fval & r_fvalPrev;
  // The first pixel of a frame is classified against the threshold being latched that cycle.
  assign w_thrEff = w_fvalRise ? iThresh : r_thrQ;
  assign w_fg     = Dval & Fval & (Grey[11:4] > w_thrEff);

  // Edge detector resets high so a frame already in progress at reset release is skipped.
  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) begin
      r_fvalPrev <= 1'b1;
      r_thrQ     <= '0;
      r_fg1      <= 1'b0;
      r_dv1      <= 1'b0;
      r_x1       <= '0;
      r_y1       <= '0;
      oBin       <= 1'b0;
      oBinDval   <= 1'b0;
    end else begin
      r_fvalPrev <= Fval;
      if (w_fvalRise) r_thrQ <= iThresh;
      r_fg1      <= w_fg;
      r_dv1      <= Dval;
      r_x1       <= iX_Cont;
      r_y1       <= iY_Cont;
      oBin       <= r_fg1 & r_dv1;
      oBinDval   <= r_dv1;
    end
  end

  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_init      = 1'b0;
    w_report    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fvalRise) begin
          w_nextState = ACCUM;
          w_init      = 1'b1;
        end
      end
      ACCUM: begin
        if (w_fvalFall) w_nextState = REPORT;
      end
      REPORT: begin
        w_report = 1'b1;
        // A new frame may start right after the gap; take it without passing through IDLE.
        if (w_fvalRise) begin
          w_nextState = ACCUM;
          w_init      = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accEn = r_fg1 & (r_state == ACCUM);

  bbox_accum #(.CNT_W(CNT_W)) u_accum (
    .i_clk   (iPclk),
    .i_rst   (iRst),
    .i_init  (w_init),
    .i_en    (w_accEn),
    .i_x     (r_x1),
    .i_y     (r_y1),
    .o_minX  (w_accMinX),
    .o_maxX  (w_accMaxX),
    .o_minY  (w_accMinY),
    .o_maxY  (w_accMaxY),
    .o_count (w_accCount)
  );

  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) begin
      oMinX     <= COORD_MIN_RESET;
      oMaxX     <= COORD_MAX_RESET;
      oMinY     <= COORD_MIN_RESET;
      oMaxY     <= COORD_MAX_RESET;
      oCount    <= '0;
      oBoxValid <= 1'b0;
    end else if (w_report) begin
      oMinX     <= w_accMinX;
      oMaxX     <= w_accMaxX;
      oMinY     <= w_accMinY;
      oMaxY     <= w_accMaxY;
      oCount    <= w_accCount;
      oBoxValid <= (w_accCount >= CNT_W'(MIN_COUNT));
    end
  end

  assign oState = r_state;

`ifdef THRESH_BBOX_OVERLAY_EN
  logic [COORD_W-1:0] r_x2, r_y2;
  logic               w_inX, w_inY, w_onX, w_onY;

  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) begin
      r_x2 <= '0;
      r_y2 <= '0;
    end else begin
      r_x2 <= r_x1;
      r_y2 <= r_y1;
    end
  end

  assign w_inX    = (r_x2 >= oMinX) && (r_x2 <= oMaxX);
  assign w_inY    = (r_y2 >= oMinY) && (r_y2 <= oMaxY);
  assign w_onX    = (r_x2 == oMinX) || (r_x2 == oMaxX);
  assign w_onY    = (r_y2 == oMinY) || (r_y2 == oMaxY);
  assign oOverlay = oBoxValid & ((w_onX & w_inY) | (w_onY & w_inX));
`endif

endmodule

// File: doc/thresh_bbox.md
THRESH_BBOX -- requirements
Module: thresh_bbox

Interface
REQ-001 Parameter MIN_COUNT, default 64: minimum foreground pixels per frame for a valid box.
REQ-002 Parameter CNT_W, default 20: width of the foreground pixel counter.
REQ-003 iPclk  in  1  pixel clock; sole clock, all logic on its rising edge.
REQ-004 iRst  in  1  reset; asynchronous, active-high.
REQ-005 iX_Cont, iY_Cont  in  16 each  pixel coordinates of the current Grey sample.
REQ-006 Dval  in  1  pixel valid.
REQ-007 Fval  in  1  frame active; high for the whole frame, low during inter-frame gap.
REQ-008 Grey  in  12  greyscale sample; only Grey[11:4] is used.
REQ-009 iThresh  in  8  threshold from the histogram stage (threshOut).
REQ-010 oBin  out  1  binarised pixel, 1 = foreground.
REQ-011 oBinDval  out  1  Dval delayed to align with oBin.
REQ-012 oMinX, oMaxX, oMinY, oMaxY  out  16 each  bounding box of the last completed frame.
REQ-013 oCount  out  CNT_W  foreground pixel count of the last completed frame.
REQ-014 oBoxValid  out  1  last completed frame had oCount >= MIN_COUNT.
REQ-015 oState  out  2  current FSM state, for debug.

Function
REQ-016 Threshold handling: iThresh SHALL be latched into thr_q on the rising edge of Fval and held constant for the whole frame.
REQ-017 Foreground test: a pixel SHALL be foreground when Dval=1, Fval=1 and Grey[11:4] > thr_q (strict compare).
REQ-018 Binarisation latency: oBin and oBinDval SHALL appear 2 cycles after their input sample.
REQ-019 oBin SHALL be 0 whenever the delayed Dval is 0.
REQ-020 FSM states SHALL be IDLE=0, ACCUM=1, REPORT=2.
- IDLE->ACCUM on Fval rising edge.
- ACCUM->REPORT on Fval falling edge.
- REPORT->IDLE after one cycle.
REQ-021 Entry to ACCUM SHALL initialise the accumulators: minX=minY=16'hFFFF, maxX=maxY=0, count=0.
REQ-022 Each foreground pixel in ACCUM SHALL update minX/maxX/minY/maxY with its coordinates (min/max compare) and increment count.
REQ-023 count SHALL saturate at all-ones and not wrap.
REQ-024 In REPORT, the accumulators SHALL be copied to the outputs, and oBoxValid = (count >= MIN_COUNT).
REQ-025 Outputs SHALL hold their values until the next REPORT.
REQ-026 Zero-foreground frame: outputs SHALL be oCount=0, oBoxValid=0, oMinX=oMinY=16'hFFFF, oMaxX=oMaxY=0.
REQ-027 A pixel arriving on the same cycle as the Fval falling edge SHALL be ignored.
REQ-028 Pixels with Fval=0 SHALL never affect the accumulators.
REQ-029 Fval rising in the cycle immediately after REPORT SHALL be taken and start a new ACCUM; no frame is lost.

Reset
REQ-030 On iRst, all state SHALL clear immediately and asynchronously:
- FSM=IDLE, thr_q=0, pipeline registers=0.
- oBin=0, oBinDval=0, oCount=0, oBoxValid=0.
- oMinX=oMinY=16'hFFFF, oMaxX=oMaxY=0.
REQ-031 Reset released mid-frame (Fval already high): the block SHALL stay in IDLE until the next Fval rising edge.

Configuration
REQ-032 Macro THRESH_BBOX_OVERLAY_EN.
- Defined: adds output oOverlay (1 bit), aligned with oBin. oOverlay=1 when the reported box is valid and the delayed (X,Y) lies on its border: X equals oMinX or oMaxX with Y inside [oMinY,oMaxY], or Y equals oMinY or oMaxY with X inside [oMinX,oMaxX].
- Undefined: port and logic are absent.

Structure
REQ-033 Package thresh_bbox_pkg SHALL hold the FSM state enum, the coordinate width (16) and the reset constants (16'hFFFF, 0).
REQ-034 Sub-module bbox_accum SHALL contain the min/max/count accumulators; the top level holds the FSM, threshold latch and binarisation pipeline.

Verification
REQ-035 iThresh=100, Grey[11:4]=100 then 101 → oBin=0 then 1, each 2 cycles later.
REQ-036 Frame with 100 foreground pixels, X 10..19 × Y 5..14, MIN_COUNT=64 → after Fval falls: oMinX=10, oMaxX=19, oMinY=5, oMaxY=14, oCount=100, oBoxValid=1.
REQ-037 All-background frame → oCount=0, oBoxValid=0, oMinX=16'hFFFF, oMaxX=0.
REQ-038 iThresh changes from 50 to 200 mid-frame → classification stays at 50 until the next Fval rise.
REQ-039 iRst pulsed mid-ACCUM at oCount=30 → outputs at reset values; the next full frame reports correctly.
REQ-040 Back-to-back frames with a one-cycle Fval gap → both frames reported with independent boxes.
